// File: rtl/imem_boot_loader.sv
// Byte-stream loader: packs bytes MSB-first into words and writes imem from 0,
// holding the CPU stalled until a halt opcode or the depth limit ends the load.
module imem_boot_loader #(
  parameter int          ADDR_W  = 6,
  parameter int          DEPTH   = 64,
  parameter logic [5:0]  HALT_OP = 6'b111111
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_data,
  output logic              cpu_run,
  output logic              done,
  output logic [ADDR_W:0]   word_cnt,
  output logic              illegal_op
);

  typedef enum logic [1:0] {
    IDLE, COLLECT, WRITE, DONE
  } state_t;

  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH-1);
  localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

  state_t      state, nxt;
  logic [1:0]  bcnt;
  logic [23:0] sh;
  logic        take, clr, legal;
  logic [5:0]  op;

  assign take = in_valid & in_ready;
  assign op   = imem_data[31:26];

  always_comb begin
    legal = (op == 6'b000000) || (op == 6'b001000) ||
            (op == 6'b100011) || (op == 6'b101011) ||
            (op == 6'b000100) || (op == 6'b000010) ||
            (op == HALT_OP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    clr = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          nxt = COLLECT;
          clr = 1'b1;
        end
      end
      COLLECT: begin
        if (take && bcnt == 2'd3) nxt = WRITE;
      end
      WRITE: begin
        if (op == HALT_OP || word_cnt == LAST) nxt = DONE;
        else                                   nxt = COLLECT;
      end
      default: nxt = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      done       <= 1'b0;
      cpu_run    <= 1'b0;
      imem_addr  <= '0;
      imem_data  <= '0;
      word_cnt   <= '0;
      illegal_op <= 1'b0;
      bcnt       <= '0;
      sh         <= '0;
    end else begin
      in_ready <= (nxt == COLLECT);
      imem_we  <= (nxt == WRITE);
      done     <= (nxt == DONE);
      cpu_run  <= (nxt == DONE);
      if (clr) begin
        word_cnt   <= '0;
        illegal_op <= 1'b0;
        bcnt       <= '0;
      end
      if (take) begin
        sh   <= {sh[15:0], in_byte};
        bcnt <= bcnt + 2'd1;
        if (bcnt == 2'd3) begin
          imem_data <= {sh, in_byte};
          imem_addr <= word_cnt[ADDR_W-1:0];
        end
      end
      if (state == WRITE) begin
        word_cnt <= word_cnt + ONE;
        if (!legal) illegal_op <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: default instance plus a DEPTH=4 one.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start0, start1;
  logic        in_valid0, in_valid1;
  logic [7:0]  in_byte0, in_byte1;
  logic        in_ready0, in_ready1;
  logic        imem_we0, imem_we1;
  logic [5:0]  imem_addr0, imem_addr1;
  logic [31:0] imem_data0, imem_data1;
  logic        cpu_run0, cpu_run1;
  logic        done0, done1;
  logic [6:0]  word_cnt0, word_cnt1;
  logic        illegal0, illegal1;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [63:0] e0, e1;

  always #5 clk = ~clk;

  imem_boot_loader u0 (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .in_valid(in_valid0), .in_byte(in_byte0), .in_ready(in_ready0),
    .imem_we(imem_we0), .imem_addr(imem_addr0), .imem_data(imem_data0),
    .cpu_run(cpu_run0), .done(done0), .word_cnt(word_cnt0),
    .illegal_op(illegal0)
  );

  imem_boot_loader #(.DEPTH(4)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .in_valid(in_valid1), .in_byte(in_byte1), .in_ready(in_ready1),
    .imem_we(imem_we1), .imem_addr(imem_addr1), .imem_data(imem_data1),
    .cpu_run(cpu_run1), .done(done1), .word_cnt(word_cnt1),
    .illegal_op(illegal1)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && imem_we0) begin
      chk("we0_in_ready", {31'b0, in_ready0}, 32'd0);
      if (q0.size() == 0) chk("we0_unexpected", 32'd1, 32'd0);
      else begin
        e0 = q0.pop_front();
        chk("we0_addr", {26'b0, imem_addr0}, e0[63:32]);
        chk("we0_data", imem_data0, e0[31:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && imem_we1) begin
      chk("we1_in_ready", {31'b0, in_ready1}, 32'd0);
      if (q1.size() == 0) chk("we1_unexpected", 32'd1, 32'd0);
      else begin
        e1 = q1.pop_front();
        chk("we1_addr", {26'b0, imem_addr1}, e1[63:32]);
        chk("we1_data", imem_data1, e1[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit sel);
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b,
                           input int gap);
    int n;
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    repeat (gap) tick();
    if (sel) begin in_valid1 = 1'b1; in_byte1 = b; end
    else     begin in_valid0 = 1'b1; in_byte0 = b; end
    n = 0;
    while (!(sel ? in_ready1 : in_ready0) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("byte_timeout", 32'd0, 32'd1);
    tick();
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
  endtask

  task automatic send_word(input bit sel, input int addr,
                           input logic [31:0] w, input int gap);
    if (sel) q1.push_back({32'(addr), w});
    else     q0.push_back({32'(addr), w});
    for (int i = 3; i >= 0; i--) send_byte(sel, w[i*8 +: 8], gap);
  endtask

  task automatic wait_done(input bit sel);
    int n;
    n = 0;
    while (!(sel ? done1 : done0) && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    start0 = 1'b0; start1 = 1'b0;
    in_valid0 = 1'b0; in_valid1 = 1'b0;
    in_byte0 = 8'h00; in_byte1 = 8'h00;
    #3;
    chk("rst_data", imem_data0, 32'd0);
    chk("rst_ctl", {14'b0, in_ready0, done0, cpu_run0, imem_we0,
                    illegal0, imem_addr0, word_cnt0}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // basic add + halt
    pulse(0);
    send_word(0, 0, 32'h00851020, 0);
    send_word(0, 1, 32'hFC000000, 0);
    wait_done(0);
    chk("t1_done", {30'b0, done0, cpu_run0}, 32'd3);
    chk("t1_cnt", {25'b0, word_cnt0}, 32'd2);
    chk("t1_illegal", {31'b0, illegal0}, 32'd0);

    // gapped valid
    pulse(0);
    send_word(0, 0, 32'h8C220004, 1);
    send_word(0, 1, 32'hAC230008, 1);
    send_word(0, 2, 32'h10220003, 1);
    send_word(0, 3, 32'hFC000000, 1);
    wait_done(0);
    chk("t2_cnt", {25'b0, word_cnt0}, 32'd4);

    // illegal opcode sticky
    pulse(0);
    send_word(0, 0, 32'h44000000, 0);
    tick();
    chk("t3_illegal_set", {31'b0, illegal0}, 32'd1);
    send_word(0, 1, 32'hFFFFFFFF, 0);
    wait_done(0);
    chk("t3_illegal_hold", {31'b0, illegal0}, 32'd1);
    chk("t3_cnt", {25'b0, word_cnt0}, 32'd2);

    // reload from DONE
    pulse(0);
    chk("t6_run_low", {30'b0, cpu_run0, done0}, 32'd0);
    chk("t6_cnt_clr", {25'b0, word_cnt0}, 32'd0);
    chk("t6_illegal_clr", {31'b0, illegal0}, 32'd0);
    send_word(0, 0, 32'hFC000000, 0);
    wait_done(0);
    chk("t6_cnt", {25'b0, word_cnt0}, 32'd1);
    chk("t6_run", {31'b0, cpu_run0}, 32'd1);

    // depth limit on the DEPTH=4 instance
    pulse(1);
    send_word(1, 0, 32'h20010001, 0);
    send_word(1, 1, 32'h20010002, 0);
    send_word(1, 2, 32'h20010003, 0);
    send_word(1, 3, 32'h20010004, 0);
    wait_done(1);
    chk("t4_done", {31'b0, done1}, 32'd1);
    chk("t4_cnt", {25'b0, word_cnt1}, 32'd4);
    in_valid1 = 1'b1;
    in_byte1 = 8'h20;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_no_ready", {31'b0, in_ready1}, 32'd0);
    end
    in_valid1 = 1'b0;
    chk("t4_cnt_hold", {25'b0, word_cnt1}, 32'd4);

    // reset mid-load
    pulse(0);
    send_byte(0, 8'h11, 0);
    send_byte(0, 8'h22, 0);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_data", imem_data0, 32'd0);
    chk("t5_rst_ctl", {14'b0, in_ready0, done0, cpu_run0, imem_we0,
                       illegal0, imem_addr0, word_cnt0}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    pulse(0);
    send_word(0, 0, 32'h20010007, 0);
    send_word(0, 1, 32'hFC000000, 0);
    wait_done(0);
    chk("t5_cnt", {25'b0, word_cnt0}, 32'd2);

    repeat (3) tick();
    chk("q0_empty", 32'(q0.size()), 32'd0);
    chk("q1_empty", 32'(q1.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
